// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states and
// default widths/reset address.
package fetch_stage_pkg;

    localparam int unsigned FETCH_IWIDTH   = 32;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, its PC, PC+4 and the decoder
// chip enable. Clear beats load; load beats hold; otherwise a bubble.
module if_id_reg #(
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned IWIDTH   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                clear,
    input  logic                hold,
    input  logic [IWIDTH-1:0]   d_instr,
    input  logic [PC_WIDTH-1:0] d_pc,
    input  logic [PC_WIDTH-1:0] d_pc4,
    output logic [IWIDTH-1:0]   q_instr,
    output logic [PC_WIDTH-1:0] q_pc,
    output logic [PC_WIDTH-1:0] q_pc4,
    output logic                q_ce
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_instr <= '0;
            q_pc    <= '0;
            q_pc4   <= '0;
            q_ce    <= 1'b0;
        end else if (clear) begin
            q_ce <= 1'b0;
        end else if (load) begin
            q_instr <= d_instr;
            q_pc    <= d_pc;
            q_pc4   <= d_pc4;
            q_ce    <= 1'b1;
        end else if (!hold) begin
            // payload is kept; only the valid bit drops
            q_ce <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, instruction-memory req/ack handshake,
// one-entry stall hold buffer, redirect with in-flight kill, IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned          PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = PC_WIDTH'(FETCH_RESET_PC),
    parameter int unsigned          IWIDTH   = FETCH_IWIDTH
) (
    input  logic                f_i_clk,
    input  logic                f_i_rst,
    input  logic                f_i_stall,
    input  logic                f_i_redirect,
    input  logic [PC_WIDTH-1:0] f_i_redirect_pc,
    output logic                f_o_imem_req,
    output logic [PC_WIDTH-1:0] f_o_imem_addr,
    input  logic                f_i_imem_ack,
    input  logic [IWIDTH-1:0]   f_i_imem_data,
    output logic [IWIDTH-1:0]   f_o_instr,
    output logic [PC_WIDTH-1:0] f_o_pc,
    output logic [PC_WIDTH-1:0] f_o_pc4,
    output logic                f_o_ce
);

    fetch_state_e         state_q;
    logic [PC_WIDTH-1:0]  pc_q;
    logic [PC_WIDTH-1:0]  req_addr_q;
    logic                 outstanding_q;
    logic                 kill_q;
    logic                 hold_valid_q;
    logic [IWIDTH-1:0]    hold_instr_q;
    logic [PC_WIDTH-1:0]  hold_pc_q;

    logic                 ack;
    logic [PC_WIDTH-1:0]  pc4;
    logic [PC_WIDTH-1:0]  redirect_aligned;
    logic                 ifid_load;
    logic                 ifid_clear;
    logic                 ifid_hold;
    logic [IWIDTH-1:0]    load_instr;
    logic [PC_WIDTH-1:0]  load_pc;

    // An issued request stays up regardless of stall; stall only gates issue.
    assign f_o_imem_req     = (state_q == FETCH_REQ) && (outstanding_q || !f_i_stall);
    assign f_o_imem_addr    = outstanding_q ? req_addr_q : pc_q;
    assign ack              = f_o_imem_req && f_i_imem_ack;
    assign pc4              = pc_q + PC_WIDTH'(4);
    assign redirect_aligned = f_i_redirect_pc & ~PC_WIDTH'(3);

    always_comb begin
        ifid_clear = f_i_redirect;
        ifid_hold  = f_i_stall;
        ifid_load  = 1'b0;
        load_instr = f_i_imem_data;
        load_pc    = pc_q;
        if (state_q == FETCH_HOLD) begin
            load_instr = hold_instr_q;
            load_pc    = hold_pc_q;
            ifid_load  = hold_valid_q && !f_i_stall;
        end else if (state_q == FETCH_REQ) begin
            ifid_load  = ack && !kill_q && !f_i_stall;
        end
    end

    always_ff @(posedge f_i_clk or posedge f_i_rst) begin
        if (f_i_rst) begin
            state_q       <= FETCH_IDLE;
            pc_q          <= RESET_PC;
            req_addr_q    <= '0;
            outstanding_q <= 1'b0;
            kill_q        <= 1'b0;
            hold_valid_q  <= 1'b0;
            hold_instr_q  <= '0;
            hold_pc_q     <= '0;
        end else begin
            outstanding_q <= f_o_imem_req && !f_i_imem_ack;
            if (f_o_imem_req && !outstanding_q)
                req_addr_q <= pc_q;
            if (f_i_redirect) begin
                // the address of a still-unacked request stays on the bus;
                // its eventual ack is dropped via kill
                pc_q         <= redirect_aligned;
                state_q      <= FETCH_REQ;
                hold_valid_q <= 1'b0;
                kill_q       <= f_o_imem_req && !f_i_imem_ack;
            end else begin
                case (state_q)
                    FETCH_IDLE: state_q <= FETCH_REQ;
                    FETCH_REQ: begin
                        if (ack) begin
                            if (kill_q) begin
                                kill_q <= 1'b0;
                            end else begin
                                pc_q <= pc4;
                                if (f_i_stall) begin
                                    hold_instr_q <= f_i_imem_data;
                                    hold_pc_q    <= pc_q;
                                    hold_valid_q <= 1'b1;
                                    state_q      <= FETCH_HOLD;
                                end
                            end
                        end
                    end
                    FETCH_HOLD: begin
                        if (!f_i_stall) begin
                            hold_valid_q <= 1'b0;
                            state_q      <= FETCH_REQ;
                        end
                    end
                    default: state_q <= FETCH_IDLE;
                endcase
            end
        end
    end

    if_id_reg #(
        .PC_WIDTH(PC_WIDTH),
        .IWIDTH  (IWIDTH)
    ) u_if_id (
        .clk    (f_i_clk),
        .rst    (f_i_rst),
        .load   (ifid_load),
        .clear  (ifid_clear),
        .hold   (ifid_hold),
        .d_instr(load_instr),
        .d_pc   (load_pc),
        .d_pc4  (load_pc + PC_WIDTH'(4)),
        .q_instr(f_o_instr),
        .q_pc   (f_o_pc),
        .q_pc4  (f_o_pc4),
        .q_ce   (f_o_ce)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async-reset sequence, and a
// randomized run checked against an in-order fetch-stream model.
module tb_fetch_stage;

    logic        f_i_clk = 1'b0;
    logic        f_i_rst;
    logic        f_i_stall;
    logic        f_i_redirect;
    logic [31:0] f_i_redirect_pc;
    logic        f_o_imem_req;
    logic [31:0] f_o_imem_addr;
    logic        f_i_imem_ack;
    logic [31:0] f_i_imem_data;
    logic [31:0] f_o_instr;
    logic [31:0] f_o_pc;
    logic [31:0] f_o_pc4;
    logic        f_o_ce;

    int checks = 0;
    int errors = 0;

    fetch_stage #(
        .PC_WIDTH(32),
        .RESET_PC(32'h0000_0000),
        .IWIDTH  (32)
    ) dut (
        .f_i_clk        (f_i_clk),
        .f_i_rst        (f_i_rst),
        .f_i_stall      (f_i_stall),
        .f_i_redirect   (f_i_redirect),
        .f_i_redirect_pc(f_i_redirect_pc),
        .f_o_imem_req   (f_o_imem_req),
        .f_o_imem_addr  (f_o_imem_addr),
        .f_i_imem_ack   (f_i_imem_ack),
        .f_i_imem_data  (f_i_imem_data),
        .f_o_instr      (f_o_instr),
        .f_o_pc         (f_o_pc),
        .f_o_pc4        (f_o_pc4),
        .f_o_ce         (f_o_ce)
    );

    always #5 f_i_clk = ~f_i_clk;

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        ak;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ce;
        logic        chk;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2008_0005;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // called just after a rising edge; returns the request seen this cycle
    task automatic run_cycle(input logic st, input logic rd, input logic [31:0] rpc,
                             input logic ak, output logic o_req, output logic [31:0] o_addr);
        f_i_stall       = st;
        f_i_redirect    = rd;
        f_i_redirect_pc = rpc;
        f_i_imem_ack    = 1'b0;
        #1;
        o_req         = f_o_imem_req;
        o_addr        = f_o_imem_addr;
        f_i_imem_ack  = ak;
        f_i_imem_data = mem_word(f_o_imem_addr);
        @(posedge f_i_clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc);
        chk({tag, "_pc"}, f_o_pc, pc);
        chk({tag, "_instr"}, f_o_instr, mem_word(pc));
        chk({tag, "_pc4"}, f_o_pc4, pc + 32'd4);
    endtask

    logic        rq;
    logic [31:0] ad;
    logic        st, rd, ak;
    logic [31:0] rpc;
    logic [31:0] exp_pc;
    logic        prev_pend;
    logic [31:0] prev_addr;
    int          wait_cnt, lat, delivered;

    initial begin
        //            st rd rpc           ak req addr          ce chk pc
        tbl.push_back('{0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 32'h0,        1, 1, 32'h0});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 32'h4,        1, 1, 32'h4});
        tbl.push_back('{0, 0, 32'h0,        0, 1, 32'h8,        0, 0, 32'h0});
        tbl.push_back('{1, 0, 32'h0,        1, 1, 32'h8,        0, 0, 32'h0});
        tbl.push_back('{1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0});
        tbl.push_back('{1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0});
        tbl.push_back('{0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h8});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 32'hC,        1, 1, 32'hC});
        tbl.push_back('{0, 0, 32'h0,        0, 1, 32'h10,       0, 0, 32'h0});
        tbl.push_back('{0, 0, 32'h0,        0, 1, 32'h10,       0, 0, 32'h0});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 32'h10,       1, 1, 32'h10});
        tbl.push_back('{0, 0, 32'h0,        0, 1, 32'h14,       0, 0, 32'h0});
        tbl.push_back('{0, 1, 32'h40,       0, 1, 32'h14,       0, 0, 32'h0});
        tbl.push_back('{0, 0, 32'h0,        0, 1, 32'h14,       0, 0, 32'h0});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 32'h14,       0, 0, 32'h0});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 32'h40,       1, 1, 32'h40});
        tbl.push_back('{0, 1, 32'h43,       1, 1, 32'h44,       0, 0, 32'h0});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 32'h40,       1, 1, 32'h40});
        tbl.push_back('{0, 0, 32'h0,        0, 1, 32'h44,       0, 0, 32'h0});
        tbl.push_back('{1, 1, 32'h80,       1, 1, 32'h44,       0, 0, 32'h0});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 32'h80,       1, 1, 32'h80});
        tbl.push_back('{1, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h80});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 32'h84,       1, 1, 32'h84});
        tbl.push_back('{0, 1, 32'hFFFF_FFFF, 1, 1, 32'h88,      0, 0, 32'h0});
        tbl.push_back('{0, 0, 32'h0,        1, 1, 32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC});
        tbl.push_back('{0, 0, 32'h0,        0, 1, 32'h0,        0, 0, 32'h0});

        f_i_rst = 1'b1;
        f_i_stall = 1'b0;
        f_i_redirect = 1'b0;
        f_i_redirect_pc = '0;
        f_i_imem_ack = 1'b0;
        f_i_imem_data = '0;
        #1;
        chk("rst_req", f_o_imem_req, 0);
        chk("rst_ce", f_o_ce, 0);
        chk("rst_instr", f_o_instr, 0);
        chk("rst_pc", f_o_pc, 0);
        chk("rst_pc4", f_o_pc4, 0);
        @(posedge f_i_clk);
        #1;
        f_i_rst = 1'b0;

        foreach (tbl[i]) begin
            run_cycle(tbl[i].st, tbl[i].rd, tbl[i].rpc, tbl[i].ak, rq, ad);
            chk($sformatf("v%0d_req", i), rq, tbl[i].e_req);
            if (tbl[i].e_req)
                chk($sformatf("v%0d_addr", i), ad, tbl[i].e_addr);
            chk($sformatf("v%0d_ce", i), f_o_ce, tbl[i].e_ce);
            if (tbl[i].chk)
                check_ifid($sformatf("v%0d", i), tbl[i].e_pc);
        end

        // request for address 0 (post-wrap) is in flight; reset between edges
        chk("wrap_req", f_o_imem_req, 1);
        chk("wrap_addr", f_o_imem_addr, 32'h0);
        #2;
        f_i_rst = 1'b1;
        #1;
        chk("async_req", f_o_imem_req, 0);
        chk("async_ce", f_o_ce, 0);
        chk("async_pc", f_o_pc, 0);
        chk("async_instr", f_o_instr, 0);
        chk("async_addr", f_o_imem_addr, 32'h0);
        @(posedge f_i_clk);
        #1;
        f_i_rst = 1'b0;
        run_cycle(0, 0, 32'h0, 1, rq, ad);
        chk("late_ack_req", rq, 0);
        chk("late_ack_ce", f_o_ce, 0);
        run_cycle(0, 0, 32'h0, 1, rq, ad);
        chk("restart_req", rq, 1);
        chk("restart_addr", ad, 32'h0);
        chk("restart_ce", f_o_ce, 1);
        check_ifid("restart", 32'h0);

        // randomized run against an in-order fetch stream model
        f_i_rst = 1'b1;
        f_i_imem_ack = 1'b0;
        @(posedge f_i_clk);
        #1;
        f_i_rst = 1'b0;
        exp_pc = 32'h0;
        wait_cnt = 0;
        lat = 0;
        delivered = 0;
        prev_pend = 1'b0;
        prev_addr = '0;
        for (int c = 0; c < 3000; c++) begin
            st  = ($urandom_range(3) == 0);
            rd  = ($urandom_range(15) == 0);
            rpc = $urandom;
            f_i_stall       = st;
            f_i_redirect    = rd;
            f_i_redirect_pc = rpc;
            f_i_imem_ack    = 1'b0;
            #1;
            rq = f_o_imem_req;
            ad = f_o_imem_addr;
            if (prev_pend) begin
                chk("rand_req_stable", rq, 1);
                chk("rand_addr_stable", ad, prev_addr);
            end
            if (rq)
                chk("rand_addr_align", {30'd0, ad[1:0]}, 32'd0);
            ak = 1'b0;
            if (rq) begin
                if (wait_cnt == 0)
                    lat = $urandom_range(2);
                if (wait_cnt >= lat)
                    ak = 1'b1;
            end
            f_i_imem_ack  = ak;
            f_i_imem_data = mem_word(ad);
            if (rq && !ak)
                wait_cnt++;
            else
                wait_cnt = 0;
            prev_pend = rq && !ak;
            prev_addr = ad;
            @(posedge f_i_clk);
            #1;
            if (rd) begin
                chk("rand_redirect_ce", f_o_ce, 0);
                exp_pc = rpc & ~32'd3;
            end else if (!st && f_o_ce) begin
                check_ifid("rand", exp_pc);
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
        end
        chk("rand_progress", (delivered >= 200) ? 32'd1 : 32'd0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
